// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes, FSM states,
// latched request payload and the alignment rule.
package data_memory_responder_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    // Size is kept as raw bits so the illegal encoding 3 survives the latch.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            write;
        logic [XLEN-1:0] wdata;
        logic [1:0]      size;
        logic            is_unsigned;
    } mem_req_t;

    // True for size 3, odd halfword lanes and any non-zero word lane.
    function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'(MEM_BYTE): bad = 1'b0;
            2'(MEM_HALF): bad = lane[0];
            2'(MEM_WORD): bad = (lane != 2'd0);
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response valid-ready channels between the CPU memory stage and the responder.
interface data_memory_responder_if;
    import data_memory_responder_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            req_write;
    logic [XLEN-1:0] req_wdata;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_error;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/data_memory_responder_mem_lane_align.sv
// Byte-lane steering: merges store data into a word and extracts/extends load data.
module mem_lane_align
    import data_memory_responder_pkg::*;
(
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      size,
    input  logic [1:0]      lane,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] merged_c,
    output logic [XLEN-1:0] load_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store merge: only the addressed lanes change.
    always_comb begin
        merged_c = old_word;
        case (size)
            2'(MEM_BYTE): merged_c[{lane, 3'b000} +: 8]        = wdata[7:0];
            2'(MEM_HALF): merged_c[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            2'(MEM_WORD): merged_c                             = wdata;
            default:      merged_c                             = old_word;
        endcase
    end

    // Load extract with sign or zero extension.
    always_comb begin
        byte_sel = old_word[{lane, 3'b000} +: 8];
        half_sel = old_word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'(MEM_BYTE): load_c = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'(MEM_HALF): load_c = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            2'(MEM_WORD): load_c = old_word;
            default:      load_c = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle load/store responder over a word array with byte/half access,
// range/alignment checking and a fixed access latency.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    data_memory_responder_if.slave      bus,
    input  logic [DEPTH-1:0][XLEN-1:0]  initial_values,
    output logic [DEPTH-1:0][XLEN-1:0]  memory_check
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_BUSY = 2'(BUSY);
    localparam logic [1:0] ST_RESP = 2'(RESP);

    logic [1:0]                 state, state_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    mem_req_t                   req_q, req_n;
    logic                       rsp_valid_q, rsp_valid_n;
    logic                       rsp_error_q, rsp_error_n;
    logic [XLEN-1:0]            rsp_rdata_q, rsp_rdata_n;
    logic [DEPTH-1:0][XLEN-1:0] mem;
    logic                       mem_we;
    logic [IDX_W-1:0]           idx;
    logic                       in_range;
    logic                       access_err;
    logic [XLEN-1:0]            merged_c;
    logic [XLEN-1:0]            load_c;

    assign idx        = req_q.addr[IDX_W+1:2];
    assign in_range   = req_q.addr[XLEN-1:2] < (XLEN-2)'(DEPTH);
    assign access_err = !in_range || access_misaligned(req_q.size, req_q.addr[1:0]);

    mem_lane_align u_align (
        .old_word    (mem[idx]),
        .wdata       (req_q.wdata),
        .size        (req_q.size),
        .lane        (req_q.addr[1:0]),
        .is_unsigned (req_q.is_unsigned),
        .merged_c    (merged_c),
        .load_c      (load_c)
    );

    assign bus.req_ready = (state == ST_IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign memory_check  = mem;

    // State, counter, latched request and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            req_q       <= req_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_error_q <= rsp_error_n;
        end
    end

    // Word array; reset reloads it, which also discards any in-flight store.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= initial_values;
        end else if (mem_we) begin
            mem[idx] <= merged_c;
        end
    end

    // Next-state and response decode.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_n       = req_q;
        rsp_valid_n = rsp_valid_q;
        rsp_rdata_n = rsp_rdata_q;
        rsp_error_n = rsp_error_q;
        mem_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_n = '{addr:        bus.req_addr,
                              write:       bus.req_write,
                              wdata:       bus.req_wdata,
                              size:        bus.req_size,
                              is_unsigned: bus.req_unsigned};
                    cnt_n   = CNT_W'(LATENCY - 1);
                    state_n = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_error_n = access_err;
                    mem_we      = req_q.write && !access_err;
                    rsp_rdata_n = (req_q.write || access_err) ? '0 : load_c;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench: loads, stores, errors, backpressure, reset abort, back-to-back.
module tb_data_memory_responder;
    import data_memory_responder_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 1;

    logic clk;
    logic reset;
    logic [DEPTH-1:0][31:0] init_vals;
    logic [DEPTH-1:0][31:0] mc_a;
    logic [DEPTH-1:0][31:0] mc_b;
    logic [DEPTH-1:0][31:0] snap;

    int tests_run;
    int tests_failed;

    data_memory_responder_if bus_a ();
    data_memory_responder_if bus_b ();

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave),
        .initial_values(init_vals), .memory_check(mc_a)
    );

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave),
        .initial_values(init_vals), .memory_check(mc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One request on bus_a with rsp_ready high; returns at the first cycle rsp_valid is seen.
    task automatic do_req(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        bus_a.req_addr = addr; bus_a.req_write = wr; bus_a.req_wdata = wd;
        bus_a.req_size = sz;   bus_a.req_unsigned = uns; bus_a.req_valid = 1'b1;
        n = 0;
        while (!bus_a.req_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_accept"}, 32'(bus_a.req_ready), 32'd1);
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_a.rsp_valid && n < 50);
        check({tag, "_lat"}, 32'(n - 1), 32'(LAT_A));
        check({tag, "_rdy_low"}, 32'(bus_a.req_ready), 32'd0);
        rd = bus_a.rsp_rdata;
        er = bus_a.rsp_error;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] b2_addr [3];
        logic [31:0] b2_exp  [3];
        int          acc_cyc [3];
        int          n, n_acc, n_rsp;

        tests_run = 0; tests_failed = 0;
        for (int i = 0; i < DEPTH; i++) init_vals[i] = 32'h1000_0000 + 32'(i);
        init_vals[1] = 32'h1122_3344;
        init_vals[3] = 32'h8899_AABB;

        reset = 1'b1;
        bus_a.req_valid = 0; bus_a.req_addr = 0; bus_a.req_write = 0; bus_a.req_wdata = 0;
        bus_a.req_size = 0;  bus_a.req_unsigned = 0; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 0; bus_b.req_addr = 0; bus_b.req_write = 0; bus_b.req_wdata = 0;
        bus_b.req_size = 2'd2; bus_b.req_unsigned = 0; bus_b.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus_a.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", 32'(bus_a.req_ready), 32'd1);
        check("rst_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rdata", bus_a.rsp_rdata, 32'd0);
        check("rst_error", 32'(bus_a.rsp_error), 32'd0);
        check("rst_array", 32'(mc_a == init_vals), 32'd1);

        // Loads
        do_req("lw", 32'h0C, 1'b0, 32'd0, 2'd2, 1'b0, rd, er);
        check("lw_rdata", rd, 32'h8899_AABB); check("lw_err", 32'(er), 32'd0);
        do_req("lb", 32'h0D, 1'b0, 32'd0, 2'd0, 1'b0, rd, er);
        check("lb_rdata", rd, 32'hFFFF_FFAA);
        do_req("lbu", 32'h0D, 1'b0, 32'd0, 2'd0, 1'b1, rd, er);
        check("lbu_rdata", rd, 32'h0000_00AA);
        do_req("lh", 32'h0E, 1'b0, 32'd0, 2'd1, 1'b0, rd, er);
        check("lh_rdata", rd, 32'hFFFF_8899);
        do_req("lhu", 32'h0E, 1'b0, 32'd0, 2'd1, 1'b1, rd, er);
        check("lhu_rdata", rd, 32'h0000_8899); check("lhu_err", 32'(er), 32'd0);

        // Stores, checked on the cycle the response appears
        do_req("sb", 32'h05, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0, rd, er);
        check("sb_rdata", rd, 32'd0); check("sb_err", 32'(er), 32'd0);
        check("sb_mem", mc_a[1], 32'h1122_EF44);
        do_req("sh", 32'h06, 1'b1, 32'h0000_CAFE, 2'd1, 1'b0, rd, er);
        check("sh_rdata", rd, 32'd0); check("sh_err", 32'(er), 32'd0);
        check("sh_mem", mc_a[1], 32'hCAFE_EF44);
        do_req("sw_top", 32'h7C, 1'b1, 32'h0BAD_F00D, 2'd2, 1'b0, rd, er);
        check("sw_top_err", 32'(er), 32'd0);
        check("sw_top_mem", mc_a[31], 32'h0BAD_F00D);

        // Errors: no write, zero data
        snap = mc_a;
        do_req("e_lw", 32'h02, 1'b0, 32'd0, 2'd2, 1'b0, rd, er);
        check("e_lw_err", 32'(er), 32'd1); check("e_lw_rdata", rd, 32'd0);
        do_req("e_sh", 32'h03, 1'b1, 32'h0000_FFFF, 2'd1, 1'b0, rd, er);
        check("e_sh_err", 32'(er), 32'd1); check("e_sh_rdata", rd, 32'd0);
        do_req("e_sw", 32'h80, 1'b1, 32'h1234_5678, 2'd2, 1'b0, rd, er);
        check("e_sw_err", 32'(er), 32'd1); check("e_sw_rdata", rd, 32'd0);
        do_req("e_sz3", 32'h0C, 1'b0, 32'd0, 2'd3, 1'b0, rd, er);
        check("e_sz3_err", 32'(er), 32'd1); check("e_sz3_rdata", rd, 32'd0);
        check("e_mem_same", 32'(mc_a == snap), 32'd1);

        // Backpressure; request inputs changed after accept must be ignored
        @(negedge clk);
        bus_a.rsp_ready = 1'b0;
        bus_a.req_addr = 32'h0C; bus_a.req_write = 1'b0; bus_a.req_size = 2'd2;
        bus_a.req_unsigned = 1'b0; bus_a.req_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.req_addr = 32'h04;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_a.rsp_valid && n < 50);
        check("bp_lat", 32'(n - 1), 32'(LAT_A));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
            check("bp_rdata", bus_a.rsp_rdata, 32'h8899_AABB);
            check("bp_ready", 32'(bus_a.req_ready), 32'd0);
        end
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready", 32'(bus_a.req_ready), 32'd1);
        check("bp_rel_valid", 32'(bus_a.rsp_valid), 32'd0);
        @(negedge clk);
        check("bp_next_acc", 32'(bus_a.req_ready), 32'd0);
        bus_a.req_valid = 1'b0;
        n = 1;
        while (!bus_a.rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("bp2_lat", 32'(n - 1), 32'(LAT_A));
        check("bp2_rdata", bus_a.rsp_rdata, 32'hCAFE_EF44);
        @(posedge clk);

        // Reset while an SW is in BUSY
        @(negedge clk);
        bus_a.req_addr = 32'h04; bus_a.req_write = 1'b1; bus_a.req_wdata = 32'h5555_5555;
        bus_a.req_size = 2'd2; bus_a.req_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) n++;
        end
        check("rb_no_rsp", 32'(n), 32'd0);
        check("rb_mem1", mc_a[1], 32'h1122_3344);
        check("rb_reload", 32'(mc_a == init_vals), 32'd1);

        // Back-to-back on the LATENCY=1 instance
        b2_addr[0] = 32'h0C; b2_exp[0] = 32'h8899_AABB;
        b2_addr[1] = 32'h04; b2_exp[1] = 32'h1122_3344;
        b2_addr[2] = 32'h08; b2_exp[2] = 32'h1000_0002;
        @(negedge clk);
        bus_b.req_addr = b2_addr[0]; bus_b.req_valid = 1'b1;
        n_acc = 0; n_rsp = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus_b.rsp_valid) begin
                if (n_rsp < 3) check("b2b_rdata", bus_b.rsp_rdata, b2_exp[n_rsp]);
                n_rsp++;
            end
            if (bus_b.req_ready && bus_b.req_valid && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                @(posedge clk); #1;
                if (n_acc < 3) bus_b.req_addr = b2_addr[n_acc];
                else bus_b.req_valid = 1'b0;
            end
        end
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_rsps", 32'(n_rsp), 32'd3);
        if (n_acc == 3) begin
            check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder that serves load/store requests from the CPU's memory stage over a valid/ready request channel and a valid/ready response channel. It adds byte/halfword access, sign/zero extension, alignment and range checking, and a configurable access latency to the word-array data memory. It sits between the CPU load/store path and the memory array, and is preloaded from `initial_values` on reset like the existing register file and memory.

## Interface
- `DEPTH`, 32: number of 32-bit words; a power of two, at least 2.
- `LATENCY`, 2: cycles from request accept to `rsp_valid`; at least 1.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_addr`  in  32  byte address
- `req_write`  in  1  1 = store, 0 = load
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `req_size`  in  2  mem_size_t: 0 byte, 1 half, 2 word, 3 illegal
- `req_unsigned`  in  1  load zero-extends (LBU/LHU); ignored for stores and words
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_rdata`  out  32  load data, extended; 0 for stores and errors
- `rsp_error`  out  1  misaligned, out-of-range or illegal size
- `initial_values`  in  32×DEPTH  array loaded on reset
- `memory_check`  out  32×DEPTH  live array contents

## Operation
- FSM states: IDLE, BUSY, RESP. There is a single outstanding request.
- In IDLE, `req_ready` = 1. On an edge with `req_valid & req_ready`, the responder:
  - latches addr, write, wdata, size and unsigned;
  - loads the counter with LATENCY-1;
  - moves to BUSY.
- In BUSY, the counter decrements each edge. On the edge where the counter is 0, the access is performed and the FSM moves to RESP.
- In RESP, `rsp_valid` = 1, and `rsp_rdata`/`rsp_error` stay stable. On an edge with `rsp_ready` = 1 the FSM returns to IDLE. The request inputs are ignored outside IDLE.
- Word index is `addr[31:2]`; byte lane is `addr[1:0]`.
- Error conditions:
  - size 3;
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - `addr[31:2]` ≥ DEPTH.
- On error: no write, `rsp_rdata` = 0, `rsp_error` = 1.
- Store byte: writes `wdata[7:0]` into lane `addr[1:0]`; the other lanes are unchanged.
- Store half: writes `wdata[15:0]` into `addr[1]`×16.
- Store word: writes the full word.
- Loads extract the selected lane. They sign-extend from bit 7 or bit 15 unless `req_unsigned` is set.
- A store response always returns `rsp_rdata` = 0.
- `memory_check` reflects the array combinationally.

## Timing
- Reset values: state IDLE, `rsp_valid` 0, `rsp_rdata` 0, `rsp_error` 0, counter 0, array = `initial_values`.
- `req_ready` is 0 while `reset` is high, then 1 from the first cycle after reset.
- Latency: if the accept is at edge t, `rsp_valid` rises after edge t+LATENCY.
- The store is visible on `memory_check` after the same edge.
- Request throughput: at least LATENCY+2 cycles per request. The next accept is at the earliest edge t+LATENCY+2, when `rsp_ready` is held at 1.
- `rsp_ready` low in RESP holds the response indefinitely with no change in value.
- `rsp_ready` is ignored outside RESP.
- `req_ready` is a registered-state decode: high only in IDLE, never in the same cycle as `rsp_valid`.
- Reset mid-operation (BUSY or RESP) abandons the request: no write, no response, and the array is reloaded.
- Counter width is `$clog2(LATENCY)`, with a minimum of 1 bit. LATENCY = 1 means BUSY lasts exactly one cycle.

## Structure
- Shared package holds:
  - `mem_size_t` enum: MEM_BYTE, MEM_HALF, MEM_WORD;
  - `mem_resp_state_t` enum: IDLE, BUSY, RESP.
- Sub-module `mem_lane_align` is purely combinational. It performs:
  - store merge: old word, wdata, size, lane → new word;
  - load extract: word, size, lane, unsigned → extended data.
- The FSM, counter and array live in the top module.

## Test plan
- Reset with `initial_values[3]` = 0x8899AABB, then LW addr 0x0C, LATENCY = 2. Required: accept at t, `rsp_valid` after t+2, `rsp_rdata` = 0x8899AABB, `rsp_error` = 0.
- Byte and half loads from addr 0x0D, with the word holding 0x8899AABB:
  - LB → 0xFFFFFFAA;
  - LBU → 0x000000AA;
  - LH at 0x0E → 0xFFFF8899;
  - LHU at 0x0E → 0x00008899.
- Stores, starting from `mem[1]` = 0x11223344:
  - SB wdata 0xDEADBEEF to 0x05 → `mem[1]` = 0x1122EF44;
  - then SH wdata 0x0000CAFE to 0x06 → `mem[1]` = 0xCAFEEF44;
  - both responses have `rsp_rdata` 0 and `rsp_error` 0.
- Errors, each giving `rsp_error` = 1, `rsp_rdata` = 0 and `memory_check` unchanged:
  - LW 0x02;
  - SH 0x03;
  - SW 0x80 with DEPTH = 32;
  - size 3.
- Backpressure and reset:
  - hold `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` stable, `req_ready` = 0;
  - after the release, the next accept happens on the following edge.
  - assert `reset` in BUSY of an SW → no write, `rsp_valid` never rises, array reloaded.
- Back-to-back with `req_valid` held at 1 and `rsp_ready` = 1, LATENCY = 1 → accepts every 3 cycles, one response per request, in order.
